// File: rtl/serial_cmp_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_cmp_ctrl_if
//
// Purpose : Bundles the handshake, operand and result signals of the serial
//           magnitude comparator so the requester and the sequencer share a
//           single port.
//
// Parameters:
//   WIDTH  operand width in bits (even, >= 2)
//
// Signals:
//   start  request from the master; sampled by the sequencer only in IDLE
//   a, b   unsigned operands, latched by the sequencer when start is accepted
//   busy   sequencer is scanning slices
//   done   one-cycle completion pulse
//   lt/eq/gt  registered, mutually exclusive magnitude result
//
// Modports:
//   master  drives start/a/b, observes busy/done/lt/eq/gt
//   slave   the comparator sequencer itself
// ----------------------------------------------------------------------------
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output start, a, b,
        input  busy, done, lt, eq, gt
    );

    modport slave (
        input  start, a, b,
        output busy, done, lt, eq, gt
    );
endinterface : serial_cmp_ctrl_if

// File: rtl/serial_cmp_ctrl.sv
// ----------------------------------------------------------------------------
// serial_cmp_ctrl
//
// Purpose : Compares two WIDTH-bit unsigned operands by reusing a single
//           2-bit magnitude-compare slice, one slice per clock, MSB-first.
//           A start/busy/done handshake frames each operation and the
//           lt/eq/gt result is registered and held until the next
//           comparison completes.
//
// Parameters:
//   WIDTH  operand width in bits; must be even and >= 2 (NSLICE = WIDTH/2)
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset (aborts any operation in flight)
//   bus    serial_cmp_ctrl_if.slave
//            start  request, sampled only in IDLE
//            a, b   operands, latched on accepted start
//            busy   high in CMP
//            done   one-cycle pulse, high in DONE
//            lt/eq/gt  registered result flags
//
// Build option:
//   EARLY_EXIT_EN  when defined, CMP ends at the first unequal slice.
//                  When undefined, every slice is always scanned (constant
//                  latency of NSLICE cycles) and a sticky "decided" record
//                  keeps the most significant unequal slice's verdict.
//                  Final flags are identical in both builds.
// ----------------------------------------------------------------------------
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_cmp_ctrl_if.slave   bus
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Reject illegal widths at elaboration rather than silently truncating.
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("serial_cmp_ctrl: WIDTH must be even and >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 2-bit magnitude-compare slice; result packed as {lt, eq}.
    function automatic logic [1:0] slice_cmp(input logic [1:0] x,
                                             input logic [1:0] y);
        return {(x < y), (x == y)};
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  a_nxt;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  b_nxt;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   idx_nxt;
    logic              lt_q;
    logic              lt_nxt;
    logic              eq_q;
    logic              eq_nxt;
    logic              gt_q;
    logic              gt_nxt;

`ifndef EARLY_EXIT_EN
    // Sticky record of the most significant unequal slice seen so far.
    logic              dec_q;
    logic              dec_nxt;
    logic              dec_lt_q;
    logic              dec_lt_nxt;
    logic              dec_gt_q;
    logic              dec_gt_nxt;
`endif

    // Current slice selection: shift the latched operands down so the slice
    // under test lands in bits [1:0].
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [1:0]        sl_res;
    logic              sl_lt;
    logic              sl_eq;

    assign a_sh   = a_q >> {idx, 1'b0};
    assign b_sh   = b_q >> {idx, 1'b0};
    assign sl_res = slice_cmp(a_sh[1:0], b_sh[1:0]);
    assign sl_lt  = sl_res[1];
    assign sl_eq  = sl_res[0];

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        a_nxt      = a_q;
        b_nxt      = b_q;
        idx_nxt    = idx;
        lt_nxt     = lt_q;
        eq_nxt     = eq_q;
        gt_nxt     = gt_q;
`ifndef EARLY_EXIT_EN
        dec_nxt    = dec_q;
        dec_lt_nxt = dec_lt_q;
        dec_gt_nxt = dec_gt_q;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    // Flags are intentionally left alone: the previous
                    // result stays visible while the new scan runs.
                    a_nxt     = bus.a;
                    b_nxt     = bus.b;
                    idx_nxt   = IDXW'(NSLICE - 1);
                    state_nxt = CMP;
`ifndef EARLY_EXIT_EN
                    dec_nxt    = 1'b0;
                    dec_lt_nxt = 1'b0;
                    dec_gt_nxt = 1'b0;
`endif
                end
            end

            CMP: begin
`ifdef EARLY_EXIT_EN
                if (!sl_eq) begin
                    lt_nxt    = sl_lt;
                    gt_nxt    = ~sl_lt;
                    eq_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (idx == '0) begin
                    lt_nxt    = 1'b0;
                    eq_nxt    = 1'b1;
                    gt_nxt    = 1'b0;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - IDXW'(1);
                end
`else
                // Only the first unequal slice may set the verdict; lower
                // slices are still scanned but cannot overwrite it.
                if (!dec_q && !sl_eq) begin
                    dec_nxt    = 1'b1;
                    dec_lt_nxt = sl_lt;
                    dec_gt_nxt = ~sl_lt;
                end

                if (idx == '0) begin
                    state_nxt = DONE;
                    if (dec_q) begin
                        lt_nxt = dec_lt_q;
                        gt_nxt = dec_gt_q;
                        eq_nxt = 1'b0;
                    end else if (!sl_eq) begin
                        lt_nxt = sl_lt;
                        gt_nxt = ~sl_lt;
                        eq_nxt = 1'b0;
                    end else begin
                        lt_nxt = 1'b0;
                        eq_nxt = 1'b1;
                        gt_nxt = 1'b0;
                    end
                end else begin
                    idx_nxt = idx - IDXW'(1);
                end
`endif
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, operand and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
`ifndef EARLY_EXIT_EN
            dec_q    <= 1'b0;
            dec_lt_q <= 1'b0;
            dec_gt_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            idx   <= idx_nxt;
            lt_q  <= lt_nxt;
            eq_q  <= eq_nxt;
            gt_q  <= gt_nxt;
`ifndef EARLY_EXIT_EN
            dec_q    <= dec_nxt;
            dec_lt_q <= dec_lt_nxt;
            dec_gt_q <= dec_gt_nxt;
`endif
        end
    end

    // busy/done decode straight from the state register, so every output
    // is register-sourced and reset drives all of them low at once.
    assign bus.busy = (state == CMP);
    assign bus.done = (state == DONE);
    assign bus.lt   = lt_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;

endmodule : serial_cmp_ctrl

// File: tb/tb_serial_cmp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_cmp_ctrl
//
// Self-checking bench for serial_cmp_ctrl (WIDTH = 8). A cycle model tracks
// the expected IDLE/CMP/DONE sequence and pushes the expected flags of every
// accepted operation into a queue; the checker pops them when done rises.
// ----------------------------------------------------------------------------
module tb_serial_cmp_ctrl;

    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    serial_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // flags are {lt, eq, gt}
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;
        int         k;
    } vec_t;

    typedef enum {M_IDLE, M_CMP, M_DONE} mstate_t;

    int         checks = 0;
    int         passes = 0;
    logic [2:0] cur_flags = '0;
    int         cur_k = NSLICE;
    mstate_t    m_state = M_IDLE;
    int         m_cnt = 0;
    logic [2:0] m_flags = '0;
    logic [2:0] exp_q[$];
    vec_t       vecs[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Slices examined before done: first differing slice from the top.
    function automatic int ref_k(input logic [7:0] a, input logic [7:0] b);
        if (!EE) return NSLICE;
        for (int i = NSLICE - 1; i >= 0; i--)
            if (a[2*i +: 2] != b[2*i +: 2]) return NSLICE - i;
        return NSLICE;
    endfunction

    task automatic set_op(input logic [7:0] a, input logic [7:0] b);
        bus.a     = a;
        bus.b     = b;
        cur_flags = {(a < b), (a == b), (a > b)};
        cur_k     = ref_k(a, b);
    endtask

    // Cycle model: accepts only in IDLE, expected result queued on acceptance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= M_IDLE;
            m_cnt   <= 0;
        end else begin
            case (m_state)
                M_IDLE: if (bus.start) begin
                    exp_q.push_back(cur_flags);
                    m_cnt   <= cur_k;
                    m_state <= M_CMP;
                end
                M_CMP: begin
                    if (m_cnt <= 1) m_state <= M_DONE;
                    else m_cnt <= m_cnt - 1;
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Checker on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            m_flags = '0;
            exp_q.delete();
        end else begin
            check("busy", bus.busy, (m_state == M_CMP));
            check("done", bus.done, (m_state == M_DONE));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL result: done with no pending op, got flags %b", {bus.lt, bus.eq, bus.gt});
                end else begin
                    m_flags = exp_q.pop_front();
                    check("flags", {bus.lt, bus.eq, bus.gt}, m_flags);
                end
            end else begin
                check("flags_held", {bus.lt, bus.eq, bus.gt}, m_flags);
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (m_state == M_IDLE) return;
        end
        checks++;
        $display("FAIL wait_idle: model still %0d after 30 cycles, expected 0", m_state);
    endtask

    initial begin
        vecs[0]  = '{8'hC0, 8'h40, 3'b001, EE ? 1 : 4};
        vecs[1]  = '{8'h24, 8'h34, 3'b100, EE ? 2 : 4};
        vecs[2]  = '{8'h12, 8'h13, 3'b100, 4};
        vecs[3]  = '{8'h5A, 8'h5A, 3'b010, 4};
        vecs[4]  = '{8'hFF, 8'h00, 3'b001, EE ? 1 : 4};
        vecs[5]  = '{8'h00, 8'hFF, 3'b100, EE ? 1 : 4};
        vecs[6]  = '{8'h80, 8'h7F, 3'b001, EE ? 1 : 4};
        vecs[7]  = '{8'h3C, 8'h3D, 3'b100, 4};
        vecs[8]  = '{8'hA5, 8'hA4, 3'b001, 4};
        vecs[9]  = '{8'h00, 8'h00, 3'b010, 4};
        vecs[10] = '{8'hC3, 8'hCF, 3'b100, EE ? 3 : 4};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", {bus.lt, bus.eq, bus.gt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven single operations; operands scrambled after acceptance.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.a     = vecs[i].a;
            bus.b     = vecs[i].b;
            cur_flags = vecs[i].flags;
            cur_k     = vecs[i].k;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = ~vecs[i].a;
            bus.b     = vecs[i].a;
            wait_idle();
        end

        // start held high for 12 cycles with operands changing every cycle.
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra;
            ra = 8'($urandom_range(0, 255));
            if (i % 3 == 0) set_op(ra, ra);
            else set_op(ra, 8'($urandom_range(0, 255)));
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();

        // start pulse during busy must not create an extra operation.
        @(negedge clk);
        set_op(8'h12, 8'h13);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        set_op(8'hF0, 8'h0F);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-CMP: outputs clear before any clock edge.
        @(negedge clk);
        set_op(8'h00, 8'h01);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_lt", bus.lt, 0);
        check("arst_eq", bus.eq, 0);
        check("arst_gt", bus.gt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        set_op(8'h01, 8'h00);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);
        check("after_rst_gt", {bus.lt, bus.eq, bus.gt}, 3'b001);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_cmp_ctrl

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
Sequencer that reuses one 2-bit magnitude-compare slice (lt/eq, the same function as the team's 2-bit comparator) to compare two WIDTH-bit unsigned operands.
- Works MSB-first, one 2-bit slice per clock.
- Uses a start/busy/done handshake.
- Registers mutually exclusive lt/eq/gt flags.
- Sits between the operand registers and any consumer that needs a magnitude decision without a full-width comparator.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; NSLICE = WIDTH/2

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A (unsigned); latched on accepted start
b  input  WIDTH  operand B (unsigned); latched on accepted start
busy  output  1  high in CMP state
done  output  1  one-cycle pulse, high in DONE state
lt  output  1  registered result A < B
eq  output  1  registered result A == B
gt  output  1  registered result A > B

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, lt=0, eq=0, gt=0; slice index=0; operand registers=0.
- States:
  - IDLE: start=1 at an edge -> latch a,b; idx=NSLICE-1; state CMP; start=0 -> stay.
  - CMP (busy=1): each edge compares slice {A[2idx+1:2idx], B[2idx+1:2idx]}.
    - Slice unequal (early exit, see Optional Feature): set lt/gt per slice; eq=0; state DONE.
    - Slice equal and idx==0: eq=1, lt=0, gt=0; state DONE.
    - Otherwise: idx-1.
  - DONE (done=1, busy=0): next edge -> IDLE unconditionally.
- Latency: start accepted at edge E; done is high for the cycle beginning at edge E+k, where k = slices examined (1..NSLICE).
- Results:
  - lt/eq/gt hold from DONE entry until the next CMP->DONE transition.
  - Results are not cleared on start; they are stale but held while busy.
  - Once the first compare has completed, exactly one flag is high.
- Start handling:
  - start is ignored in CMP and DONE, including while held high.
  - start held high continuously gives back-to-back operations: IDLE is occupied for one cycle between operations.
- a/b changes after acceptance do not affect the operation in flight.
- rst asserted mid-operation: immediate abort; all outputs go to reset values; no done pulse.
- Slice compare is purely internal combinational logic. Flags are registered; no combinational path from a/b to any output.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined: CMP ends at the first unequal slice, so k = index of the first differing slice from the top plus 1.
- Undefined:
  - All NSLICE slices are always scanned, giving constant latency k=NSLICE.
  - A sticky "decided" flag keeps the first (most significant) unequal slice's lt/gt.
  - Lower slices cannot overwrite it.
  - Final flags are identical to the defined case.

Test Plan:
- WIDTH=8, rst pulse mid-clock (asynchronous) -> busy/done/lt/eq/gt all 0 immediately, without waiting for a clock edge.
- a=8'hC0, b=8'h40, start 1 cycle -> gt=1, lt=0, eq=0; done at E+1 with EARLY_EXIT_EN, at E+4 without.
- a=8'h24, b=8'h34 -> lt=1; done at E+2 with EARLY_EXIT_EN, E+4 without.
- a=8'h12, b=8'h13 -> lt=1 (decided in last slice); a=8'h5A, b=8'h5A -> eq=1; both done at E+4 in either build.
- Handshake: start held high for 12 cycles, a/b changed every cycle -> ops accepted only in IDLE, each done exactly 1 cycle wide, results match operands latched at acceptance; start pulse during busy -> no extra op.
- Reset mid-CMP (a=8'h00, b=8'h01, rst at E+2) -> no done pulse, flags 0, state IDLE; next start with a=8'h01, b=8'h00 -> gt=1.
